// File: rtl/gemm_inst_sequencer.sv
// gemm_inst_sequencer
//   Holds a host-loaded instruction program and runs it to completion,
//   sequencing the systolic array through WARMUP / STEADY / DRAIN and
//   supplying the SRAM read windows for the top, left and down banks.
//
//   Instruction layout (MSB first): {opcode, buf_id, mem_loc}
//     LD       (0010) : start_addr[buf_id] <= mem_loc[LOG2_SRAM_BANK_DEPTH-1:0]
//     ST       (0011) : end_addr[buf_id]   <= mem_loc[LOG2_SRAM_BANK_DEPTH-1:0]
//     GEMM     (0100) : WARMUP for WARMUP_CYCLES, then STEADY for the top window length
//     DRAINSYS (0101) : DRAIN for DRAIN_CYCLES
//     HALT     (0000) : end of program
//   Any other opcode, or buf_id 3 on LD/ST, sets the sticky error flag and ends the program.
//
// Ports
//   clk, rst_n                      : clock, asynchronous active-low reset
//   i_inst_wr_en/addr/data          : instruction memory write port (ignored while busy)
//   i_start                         : run program from PC 0 (accepted only when idle)
//   o_busy, o_done, o_err, o_pc     : status handshake, sticky error, program counter
//   o_ctrl_state                    : 0 idle, 1 warmup, 2 steady, 3 drain
//   o_{top,left,down}_sram_rd_{start,end}_addr : bank read windows
module gemm_inst_sequencer #(
    parameter int NUM_ROW               = 4,
    parameter int NUM_COL               = 4,
    parameter int LOG2_SRAM_BANK_DEPTH  = 5,
    parameter int CTRL_WIDTH            = 4,
    parameter int INST_WIDTH            = 16,
    parameter int LOG2_INST_MEMORY_SIZE = 4,
    parameter int OPCODE_WIDTH          = 4,
    parameter int BUF_ID_WIDTH          = 2,
    parameter int MEM_LOC_WIDTH         = 10,
    parameter int WARMUP_CYCLES         = 1,
    parameter int DRAIN_CYCLES          = NUM_ROW + NUM_COL
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_inst_wr_en,
    input  logic [LOG2_INST_MEMORY_SIZE-1:0] i_inst_wr_addr,
    input  logic [INST_WIDTH-1:0]            i_inst_wr_data,
    input  logic                             i_start,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_err,
    output logic [LOG2_INST_MEMORY_SIZE-1:0] o_pc,
    output logic [CTRL_WIDTH-1:0]            o_ctrl_state,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]  o_top_sram_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]  o_top_sram_rd_end_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]  o_left_sram_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]  o_left_sram_rd_end_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]  o_down_sram_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]  o_down_sram_rd_end_addr
);

    localparam int INST_MEMORY_SIZE = 2 ** LOG2_INST_MEMORY_SIZE;
    localparam int NUM_BANKS        = 3;
    localparam int CNT_W            = 16;

    localparam logic [OPCODE_WIDTH-1:0] OP_HALT     = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_LD       = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_ST       = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_GEMM     = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_DRAINSYS = OPCODE_WIDTH'(5);

    localparam logic [LOG2_INST_MEMORY_SIZE-1:0] PC_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WARMUP,
        S_STEADY,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                             state_reg, state_next;
    logic [LOG2_INST_MEMORY_SIZE-1:0]   pc_reg, pc_next;
    logic [CNT_W-1:0]                   cnt_reg, cnt_next;
    logic                               err_reg, err_next;
    logic                               advance;
    logic                               ld_fire, st_fire;

    // ---------------- instruction memory ----------------
    logic [INST_WIDTH-1:0] inst_mem [INST_MEMORY_SIZE];
    logic [INST_WIDTH-1:0] inst_rd_reg;
    logic                  inst_wr_fire;

    assign inst_wr_fire = i_inst_wr_en && (state_reg == S_IDLE);

    // The read address is the PC; data is valid in DECODE, one cycle after FETCH.
    always_ff @(posedge clk) begin
        if (inst_wr_fire) begin
            inst_mem[i_inst_wr_addr] <= i_inst_wr_data;
        end
        inst_rd_reg <= inst_mem[pc_reg];
    end

    logic [OPCODE_WIDTH-1:0]         opcode;
    logic [BUF_ID_WIDTH-1:0]         buf_id;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] loc;

    assign opcode = inst_rd_reg[INST_WIDTH-1 -: OPCODE_WIDTH];
    assign buf_id = inst_rd_reg[MEM_LOC_WIDTH +: BUF_ID_WIDTH];
    assign loc    = inst_rd_reg[LOG2_SRAM_BANK_DEPTH-1:0];

    // ---------------- bank address registers ----------------
    logic [LOG2_SRAM_BANK_DEPTH-1:0] start_addr_reg [NUM_BANKS];
    logic [LOG2_SRAM_BANK_DEPTH-1:0] end_addr_reg   [NUM_BANKS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    start_addr_reg[gi] <= '0;
                    end_addr_reg[gi]   <= '0;
                end else begin
                    if (ld_fire && (buf_id == BUF_ID_WIDTH'(gi))) begin
                        start_addr_reg[gi] <= loc;
                    end
                    if (st_fire && (buf_id == BUF_ID_WIDTH'(gi))) begin
                        end_addr_reg[gi] <= loc;
                    end
                end
            end
        end
    endgenerate

    // STEADY runs for (end - start + 1) mod depth cycles, with 0 meaning a
    // full wrap. The counter holds "cycles remaining minus one", so the load
    // value is simply end - start in bank-address arithmetic; the natural
    // wrap of that subtraction covers the full-depth case for free.
    logic [LOG2_SRAM_BANK_DEPTH-1:0] steady_last;
    assign steady_last = end_addr_reg[0] - start_addr_reg[0];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            pc_reg    <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        advance    = 1'b0;
        ld_fire    = 1'b0;
        st_fire    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (i_start) begin
                    state_next = S_FETCH;
                    pc_next    = '0;
                    err_next   = 1'b0;
                end
            end
            S_FETCH: begin
                state_next = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LD, OP_ST: begin
                        if (buf_id >= BUF_ID_WIDTH'(NUM_BANKS)) begin
                            err_next   = 1'b1;
                            state_next = S_DONE;
                        end else begin
                            ld_fire = (opcode == OP_LD);
                            st_fire = (opcode == OP_ST);
                            advance = 1'b1;
                        end
                    end
                    OP_GEMM: begin
                        state_next = S_WARMUP;
                        cnt_next   = CNT_W'(WARMUP_CYCLES - 1);
                    end
                    OP_DRAINSYS: begin
                        state_next = S_DRAIN;
                        cnt_next   = CNT_W'(DRAIN_CYCLES - 1);
                    end
                    OP_HALT: begin
                        state_next = S_DONE;
                    end
                    default: begin
                        err_next   = 1'b1;
                        state_next = S_DONE;
                    end
                endcase
            end
            S_WARMUP: begin
                if (cnt_reg == '0) begin
                    state_next = S_STEADY;
                    cnt_next   = CNT_W'(steady_last);
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_STEADY, S_DRAIN: begin
                if (cnt_reg == '0) begin
                    advance = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Completing the last memory slot ends the program; the PC never wraps.
        if (advance) begin
            if (pc_reg == PC_LAST) begin
                state_next = S_DONE;
            end else begin
                pc_next    = pc_reg + 1'b1;
                state_next = S_FETCH;
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        o_ctrl_state = '0;
        case (state_reg)
            S_WARMUP: o_ctrl_state = CTRL_WIDTH'(1);
            S_STEADY: o_ctrl_state = CTRL_WIDTH'(2);
            S_DRAIN:  o_ctrl_state = CTRL_WIDTH'(3);
            default:  o_ctrl_state = '0;
        endcase
    end

    assign o_busy = (state_reg != S_IDLE);
    assign o_done = (state_reg == S_DONE);
    assign o_err  = err_reg;
    assign o_pc   = pc_reg;

    assign o_top_sram_rd_start_addr  = start_addr_reg[0];
    assign o_top_sram_rd_end_addr    = end_addr_reg[0];
    assign o_left_sram_rd_start_addr = start_addr_reg[1];
    assign o_left_sram_rd_end_addr   = end_addr_reg[1];
    assign o_down_sram_rd_start_addr = start_addr_reg[2];
    assign o_down_sram_rd_end_addr   = end_addr_reg[2];

endmodule

// File: tb/tb_gemm_inst_sequencer.sv
// Testbench for gemm_inst_sequencer: directed and random programs checked
// against a program-level reference model that expands each instruction into
// its expected per-cycle ctrl_state / pc trace.
module tb_gemm_inst_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_inst_wr_en;
    logic [3:0]  i_inst_wr_addr;
    logic [15:0] i_inst_wr_data;
    logic        i_start;
    logic        o_busy, o_done, o_err;
    logic [3:0]  o_pc;
    logic [3:0]  o_ctrl_state;
    logic [4:0]  top_s, top_e, left_s, left_e, down_s, down_e;

    always #5 clk = ~clk;

    gemm_inst_sequencer dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .i_inst_wr_en              (i_inst_wr_en),
        .i_inst_wr_addr            (i_inst_wr_addr),
        .i_inst_wr_data            (i_inst_wr_data),
        .i_start                   (i_start),
        .o_busy                    (o_busy),
        .o_done                    (o_done),
        .o_err                     (o_err),
        .o_pc                      (o_pc),
        .o_ctrl_state              (o_ctrl_state),
        .o_top_sram_rd_start_addr  (top_s),
        .o_top_sram_rd_end_addr    (top_e),
        .o_left_sram_rd_start_addr (left_s),
        .o_left_sram_rd_end_addr   (left_e),
        .o_down_sram_rd_start_addr (down_s),
        .o_down_sram_rd_end_addr   (down_e)
    );

    int total  = 0;
    int passed = 0;

    logic [15:0] prog [16];      // what the host has successfully written
    int          m_start [3];    // model bank windows
    int          m_end   [3];

    localparam int DEPTH  = 32;
    localparam int WARMUP = 1;
    localparam int DRAIN  = 8;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mk(input int op, input int b, input int loc);
        logic [15:0] w;
        w = {op[3:0], b[1:0], loc[9:0]};
        return w;
    endfunction

    task automatic write_inst(input int a, input logic [15:0] d);
        i_inst_wr_en   = 1'b1;
        i_inst_wr_addr = a[3:0];
        i_inst_wr_data = d;
        tick();
        i_inst_wr_en   = 1'b0;
        prog[a]        = d;
    endtask

    task automatic check_addrs(input string tag);
        chk({tag, "_top_s"},  32'(top_s),  32'(m_start[0]));
        chk({tag, "_top_e"},  32'(top_e),  32'(m_end[0]));
        chk({tag, "_left_s"}, 32'(left_s), 32'(m_start[1]));
        chk({tag, "_left_e"}, 32'(left_e), 32'(m_end[1]));
        chk({tag, "_down_s"}, 32'(down_s), 32'(m_start[2]));
        chk({tag, "_down_e"}, 32'(down_e), 32'(m_end[2]));
    endtask

    // Runs the current program. Optionally writes addr 0 in the same cycle as
    // start (wr0) and/or pulses start + a write at trace index inj_k.
    task automatic run_program(input string tag, input int inj_k, input int inj_addr,
                               input logic [15:0] inj_data, input logic wr0,
                               input logic [15:0] wr0_data);
        int          q_ctrl[$];
        int          q_pc[$];
        int          pc, op, b, loc, len, last;
        logic [15:0] w;
        bit          stop, m_err;

        if (wr0) begin
            i_inst_wr_en   = 1'b1;
            i_inst_wr_addr = 4'd0;
            i_inst_wr_data = wr0_data;
            prog[0]        = wr0_data;
        end

        // Reference model: expand the program into the expected cycle trace.
        pc = 0; stop = 0; m_err = 0;
        while (!stop) begin
            w   = prog[pc];
            op  = int'(w[15:12]);
            b   = int'(w[11:10]);
            loc = int'(w[4:0]);
            q_ctrl.push_back(0); q_pc.push_back(pc);   // fetch
            q_ctrl.push_back(0); q_pc.push_back(pc);   // decode
            case (op)
                2, 3: begin
                    if (b == 3) begin
                        m_err = 1; stop = 1;
                    end else if (op == 2) m_start[b] = loc;
                    else m_end[b] = loc;
                end
                4: begin
                    len = (((m_end[0] - m_start[0] + 1) % DEPTH) + DEPTH) % DEPTH;
                    if (len == 0) len = DEPTH;
                    for (int i = 0; i < WARMUP; i++) begin q_ctrl.push_back(1); q_pc.push_back(pc); end
                    for (int i = 0; i < len; i++)    begin q_ctrl.push_back(2); q_pc.push_back(pc); end
                end
                5: for (int i = 0; i < DRAIN; i++) begin q_ctrl.push_back(3); q_pc.push_back(pc); end
                0: stop = 1;
                default: begin m_err = 1; stop = 1; end
            endcase
            if (!stop) begin
                if (pc == 15) stop = 1;
                else pc++;
            end
        end
        q_ctrl.push_back(0); q_pc.push_back(pc);       // done cycle
        last = q_ctrl.size() - 1;

        i_start = 1'b1;
        tick();
        i_start      = 1'b0;
        i_inst_wr_en = 1'b0;

        for (int k = 0; k <= last; k++) begin
            chk({tag, "_ctrl"}, 32'(o_ctrl_state), 32'(q_ctrl[k]));
            chk({tag, "_pc"},   32'(o_pc),         32'(q_pc[k]));
            chk({tag, "_busy"}, 32'(o_busy),       32'd1);
            chk({tag, "_done"}, 32'(o_done),       (k == last) ? 32'd1 : 32'd0);
            chk({tag, "_err"},  32'(o_err),        (k == last) ? 32'(m_err) : 32'd0);
            if (k == inj_k) begin
                i_start        = 1'b1;
                i_inst_wr_en   = 1'b1;
                i_inst_wr_addr = inj_addr[3:0];
                i_inst_wr_data = inj_data;
            end
            tick();
            i_start      = 1'b0;
            i_inst_wr_en = 1'b0;
        end
        chk({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_idle_done"}, 32'(o_done), 32'd0);
        chk({tag, "_idle_ctrl"}, 32'(o_ctrl_state), 32'd0);
        chk({tag, "_final_pc"},  32'(o_pc),  32'(pc));
        chk({tag, "_final_err"}, 32'(o_err), 32'(m_err));
        check_addrs(tag);
        $display("program %s: %0d cycles to done, pc=%0d err=%0d", tag, last + 1, pc, m_err);
    endtask

    initial begin
        int v, b, hit;

        rst_n          = 1'b0;
        i_inst_wr_en   = 1'b0;
        i_inst_wr_addr = '0;
        i_inst_wr_data = '0;
        i_start        = 1'b0;
        for (int i = 0; i < 3; i++) begin m_start[i] = 0; m_end[i] = 0; end
        for (int i = 0; i < 16; i++) prog[i] = '0;
        tick();
        tick();

        // Reset state
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_err",  32'(o_err),  32'd0);
        chk("rst_pc",   32'(o_pc),   32'd0);
        chk("rst_ctrl", 32'(o_ctrl_state), 32'd0);
        check_addrs("rst");
        rst_n = 1'b1;
        tick();

        // LD top 3, ST top 6, GEMM, HALT -> warmup 1, steady 4
        write_inst(0, mk(2, 0, 3));
        write_inst(1, mk(3, 0, 6));
        write_inst(2, mk(4, 0, 0));
        write_inst(3, mk(0, 0, 0));
        run_program("gemm_basic", -1, 0, '0, 1'b0, '0);

        // DRAINSYS -> ctrl 3 for 8 cycles
        write_inst(0, mk(5, 0, 0));
        write_inst(1, mk(0, 0, 0));
        run_program("drain", -1, 0, '0, 1'b0, '0);

        // Address wrap: LD top 30, ST top 1 -> steady 4; upper mem_loc bits ignored
        write_inst(0, mk(2, 0, 10'h3C0 | 30));
        write_inst(1, mk(3, 0, 10'h2A0 | 1));
        write_inst(2, mk(4, 0, 0));
        write_inst(3, mk(0, 0, 0));
        run_program("wrap", -1, 0, '0, 1'b0, '0);

        // Full wrap: start == end + 1 -> steady 32
        write_inst(0, mk(2, 0, 7));
        write_inst(1, mk(3, 0, 6));
        run_program("fullwrap", -1, 0, '0, 1'b0, '0);

        // Illegal opcode at PC 2
        write_inst(0, mk(2, 1, 2));
        write_inst(1, mk(3, 2, 9));
        write_inst(2, mk(9, 0, 0));
        run_program("illegal", -1, 0, '0, 1'b0, '0);
        // Start with simultaneous write of HALT at addr 0; error cleared
        run_program("clear_err", -1, 0, '0, 1'b1, mk(0, 0, 0));

        // Illegal buf_id 3 on LD
        write_inst(0, mk(2, 3, 5));
        run_program("bad_buf", -1, 0, '0, 1'b0, '0);

        // Mid-program start and write are ignored; rerun proves memory unchanged
        write_inst(0, mk(2, 1, 7));
        write_inst(1, mk(4, 0, 0));
        write_inst(2, mk(2, 2, 4));
        write_inst(3, mk(5, 0, 0));
        write_inst(4, mk(0, 0, 0));
        write_inst(5, mk(0, 0, 0));
        run_program("inject", 3, 0, mk(2, 1, 9), 1'b0, '0);
        write_inst(0, mk(3, 1, 11));
        run_program("inject2", 6, 0, mk(2, 1, 9), 1'b0, '0);
        write_inst(0, mk(2, 1, 20));
        run_program("inject_chk", -1, 0, '0, 1'b0, '0);

        // 16 LDs with no HALT -> done after PC 15, 33 cycles
        for (int i = 0; i < 16; i++) write_inst(i, mk(2, i % 3, i + 3));
        run_program("ld16", -1, 0, '0, 1'b0, '0);

        // Reset mid-STEADY
        write_inst(0, mk(2, 0, 0));
        write_inst(1, mk(3, 0, 31));
        write_inst(2, mk(4, 0, 0));
        write_inst(3, mk(0, 0, 0));
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        hit = 0;
        for (int c = 0; c < 50 && !hit; c++) begin
            if (o_ctrl_state == 4'd2) hit = 1;
            else tick();
        end
        chk("rst_mid_reach_steady", 32'(hit), 32'd1);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin m_start[i] = 0; m_end[i] = 0; end
        chk("rst_mid_busy", 32'(o_busy), 32'd0);
        chk("rst_mid_done", 32'(o_done), 32'd0);
        chk("rst_mid_err",  32'(o_err),  32'd0);
        chk("rst_mid_pc",   32'(o_pc),   32'd0);
        chk("rst_mid_ctrl", 32'(o_ctrl_state), 32'd0);
        check_addrs("rst_mid");
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_mid_no_done", 32'(o_done), 32'd0);
            chk("rst_mid_idle",    32'(o_busy), 32'd0);
        end
        // Memory retained across reset
        run_program("after_rst", -1, 0, '0, 1'b0, '0);

        // Random programs
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 16; a++) begin
                v = $urandom_range(0, 19);
                b = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
                if (v <= 6)       write_inst(a, mk(2, b, int'($urandom_range(0, 1023))));
                else if (v <= 12) write_inst(a, mk(3, b, int'($urandom_range(0, 1023))));
                else if (v <= 15) write_inst(a, mk(4, int'($urandom_range(0, 3)), int'($urandom_range(0, 1023))));
                else if (v <= 17) write_inst(a, mk(5, 0, 0));
                else if (v == 18) write_inst(a, mk(0, 0, 0));
                else              write_inst(a, mk(int'($urandom_range(6, 15)), 0, 0));
            end
            run_program($sformatf("rand%0d", r), -1, 0, '0, 1'b0, '0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
